// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetches instructions from instruction memory at the current
//               PC, presents them to decode, and resolves JMP/BEQZ/HALT into
//               the PC's increment/jump controls with one pc_step per
//               retired instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int         DATA_W   = 16,
    parameter int         ADDR_W   = 4,
    parameter int         TIMEOUT  = 15,
    parameter logic [3:0] OPC_JMP  = 4'hA,
    parameter logic [3:0] OPC_BEQZ = 4'hB,
    parameter logic [3:0] OPC_HALT = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instruction_addr,
    output logic              pc_step,
    output logic [7:0]        pc_increment,
    output logic              jump,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              zero_flag,
    output logic              halted,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Last wait-counter value before the memory is declared unresponsive.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_wait_cnt;
    logic [7:0]          w_wait_cnt_next;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   w_instr_next;
    logic                r_fetch_err;
    logic                w_fetch_err_next;

    logic [3:0]          w_opcode;
    logic [ADDR_W-1:0]   w_field;
    logic [ADDR_W-1:0]   w_addr_neg;
    logic [ADDR_W-1:0]   w_inc;

    assign w_opcode   = r_instr[15:12];
    assign w_field    = r_instr[ADDR_W-1:0];
    // A relative step of (-addr) mod 2^ADDR_W lands the PC on address 0,
    // which is how JMP 0 is expressed since increment 0 means +1.
    assign w_addr_neg = {ADDR_W{1'b0}} - instruction_addr;

    assign pc_increment = {{(8-ADDR_W){1'b0}}, w_inc};
    assign instr        = r_instr;
    assign halted       = (r_state == S_HALT);
    assign fetch_err    = r_fetch_err;

    // State, captured instruction, wait counter and sticky error register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_instr     <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_instr     <= w_instr_next;
            r_fetch_err <= w_fetch_err_next;
        end
    end

    // Next-state logic plus memory handshake and PC step encoding.
    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_instr_next     = r_instr;
        w_fetch_err_next = r_fetch_err;
        imem_req         = 1'b0;
        imem_addr        = '0;
        instr_valid      = 1'b0;
        pc_step          = 1'b0;
        jump             = 1'b0;
        w_inc            = '0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end

            S_REQ: begin
                imem_req        = 1'b1;
                imem_addr       = instruction_addr;
                w_wait_cnt_next = 8'd0;
                if (imem_valid) begin
                    w_instr_next = imem_data;
                    w_state_next = S_ISSUE;
                end else begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                // The PC cannot move while a fetch is outstanding, so the
                // live PC value is a stable fetch address.
                imem_req  = 1'b1;
                imem_addr = instruction_addr;
                if (imem_valid) begin
                    w_instr_next = imem_data;
                    w_state_next = S_ISSUE;
                end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                    w_fetch_err_next = 1'b1;
                    w_state_next     = S_HALT;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end

            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (w_opcode == OPC_HALT) begin
                        // PC stays frozen on the HALT instruction.
                        w_state_next = S_HALT;
                    end else if (w_opcode == OPC_JMP) begin
                        pc_step      = 1'b1;
                        w_state_next = S_REQ;
                        if (w_field != '0) begin
                            w_inc = w_field;
                            jump  = 1'b1;
                        end else if (instruction_addr == '0) begin
                            // JMP 0 at address 0 would spin forever.
                            w_state_next = S_HALT;
                        end else begin
                            w_inc = w_addr_neg;
                        end
                    end else if (w_opcode == OPC_BEQZ) begin
                        pc_step      = 1'b1;
                        w_state_next = S_REQ;
                        if (zero_flag) begin
                            if (w_field == '0) begin
                                // Taken branch by 0 is a self-loop.
                                w_state_next = S_HALT;
                            end else begin
                                w_inc = w_field;
                            end
                        end
                    end else begin
                        pc_step      = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
            end

            S_HALT: begin
                w_state_next = S_HALT;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. Models the PC and
//               instruction memory around the DUT and predicts each next
//               fetch address from the instruction-set rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  pc;
    logic        pc_step;
    logic [7:0]  pc_increment;
    logic        jump;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data  = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        zero_flag   = 1'b0;
    logic        halted;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] prog [16];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .TIMEOUT (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_addr (pc),
        .pc_step          (pc_step),
        .pc_increment     (pc_increment),
        .jump             (jump),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_data        (imem_data),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .zero_flag        (zero_flag),
        .halted           (halted),
        .fetch_err        (fetch_err)
    );

    // Program counter: increment 0 means +1, jump loads the low nibble.
    always @(posedge clk) begin
        if (!rst)
            pc <= 4'd0;
        else if (pc_step) begin
            if (jump)
                pc <= pc_increment[3:0];
            else if (pc_increment == 8'h00)
                pc <= pc + 4'd1;
            else
                pc <= pc + pc_increment[3:0];
        end
    end

    // Hang guard.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pc_step"},      pc_step,      0);
        chk({tag, "_pc_increment"}, pc_increment, 0);
        chk({tag, "_jump"},         jump,         0);
        chk({tag, "_imem_req"},     imem_req,     0);
        chk({tag, "_imem_addr"},    imem_addr,    0);
        chk({tag, "_instr_valid"},  instr_valid,  0);
        chk({tag, "_instr"},        instr,        0);
        chk({tag, "_halted"},       halted,       0);
        chk({tag, "_fetch_err"},    fetch_err,    0);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        imem_valid  = 1'b0;
        instr_ready = 1'b0;
        zero_flag   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
    endtask

    function automatic logic [15:0] gen_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55)      return {4'($urandom_range(0, 9)), 12'($urandom)};
        else if (r < 75) return {4'hA, 12'($urandom)};
        else if (r < 93) return {4'hB, 12'($urandom)};
        else             return {4'hF, 12'($urandom)};
    endfunction

    // Fetch one instruction at exp_addr, retire it, and predict the next PC.
    task automatic run_instr(input logic [3:0] exp_addr, input int lat, input int hold,
                             input logic z, output logic [3:0] nxt, output bit stop);
        logic [15:0] w;
        logic [3:0]  op;
        logic [3:0]  f;
        bit          step_exp;
        bit          jump_exp;
        bit          halt_exp;
        logic [7:0]  inc_exp;
        int          n;
        stop = 1'b0;
        nxt  = exp_addr;
        n    = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", imem_req, 1);
        if (imem_req !== 1'b1) begin
            stop = 1'b1;
            return;
        end
        chk("imem_addr", imem_addr, exp_addr);
        w = prog[exp_addr];
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("req_held", imem_req, 1);
            chk("addr_held", imem_addr, exp_addr);
        end
        imem_valid = 1'b1;
        imem_data  = w;
        tick();
        imem_valid = 1'b0;
        imem_data  = 16'($urandom);
        for (int i = 0; i < hold; i++) begin
            chk("hold_instr_valid", instr_valid, 1);
            chk("hold_instr", instr, w);
            chk("hold_no_step", pc_step, 0);
            zero_flag = 1'($urandom);
            tick();
        end
        chk("instr_valid", instr_valid, 1);
        chk("instr", instr, w);

        // Reference: architectural next PC and step encoding.
        op       = w[15:12];
        f        = w[3:0];
        step_exp = 1'b1;
        jump_exp = 1'b0;
        halt_exp = 1'b0;
        inc_exp  = 8'h00;
        nxt      = exp_addr + 4'd1;
        if (op == 4'hF) begin
            step_exp = 1'b0;
            halt_exp = 1'b1;
            nxt      = exp_addr;
        end else if (op == 4'hA) begin
            if (f != 4'd0) begin
                jump_exp = 1'b1;
                inc_exp  = {4'h0, f};
                nxt      = f;
            end else begin
                inc_exp = 8'((16 - int'(exp_addr)) % 16);
                nxt     = 4'd0;
                if (exp_addr == 4'd0) begin
                    halt_exp = 1'b1;
                    nxt      = 4'd1;
                end
            end
        end else if (op == 4'hB && z) begin
            inc_exp = {4'h0, f};
            nxt     = 4'((int'(exp_addr) + int'(f)) % 16);
            if (f == 4'd0) begin
                halt_exp = 1'b1;
                nxt      = exp_addr + 4'd1;
            end
        end

        instr_ready = 1'b1;
        zero_flag   = z;
        #1;
        chk("pc_step", pc_step, step_exp);
        chk("pc_increment", pc_increment, inc_exp);
        chk("jump", jump, jump_exp);
        tick();
        instr_ready = 1'b0;
        zero_flag   = 1'($urandom);
        chk("pc_next", pc, nxt);
        chk("halted", halted, halt_exp);
        chk("step_once", pc_step, 0);
        if (halt_exp) begin
            stop = 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk("halt_no_req", imem_req, 0);
                chk("halt_stays", halted, 1);
                tick();
            end
        end
    endtask

    task automatic run_prog(input int max_instr, input int lat, input int hold, input logic z,
                            input bit randomize_timing);
        logic [3:0] addr;
        logic [3:0] nxt;
        bit         stop;
        int         l;
        int         h;
        logic       zz;
        addr = 4'd0;
        for (int k = 0; k < max_instr; k++) begin
            l  = randomize_timing ? $urandom_range(0, 4) : lat;
            h  = randomize_timing ? $urandom_range(0, 3) : hold;
            zz = randomize_timing ? 1'($urandom) : z;
            run_instr(addr, l, h, zz, nxt, stop);
            if (stop) break;
            addr = nxt;
        end
    endtask

    initial begin
        logic [3:0] nxt;
        bit         stop;
        int         n;

        // Sequential NOPs with 1-cycle memory latency.
        for (int i = 0; i < 16; i++) prog[i] = 16'h1234;
        do_reset();
        run_prog(4, 1, 0, 1'b0, 1'b0);

        // JMP 7 at address 2.
        prog[2] = 16'hA007;
        do_reset();
        run_prog(5, 1, 0, 1'b0, 1'b0);

        // JMP 0 at address 5 returns to 0 via a relative step.
        prog[2] = 16'h1234;
        prog[5] = 16'hA000;
        do_reset();
        run_prog(8, 1, 0, 1'b0, 1'b0);

        // JMP 0 at address 0 is a self-loop.
        prog[0] = 16'hA000;
        do_reset();
        run_prog(2, 0, 0, 1'b0, 1'b0);

        // BEQZ +3 at address 14, taken then not taken.
        for (int i = 0; i < 16; i++) prog[i] = 16'h2345;
        prog[0]  = 16'hA00E;
        prog[14] = 16'hB003;
        do_reset();
        run_prog(4, 1, 0, 1'b1, 1'b0);
        do_reset();
        run_prog(4, 1, 0, 1'b0, 1'b0);

        // Decode backpressure for 5 cycles.
        do_reset();
        run_prog(3, 2, 5, 1'b0, 1'b0);

        // HALT opcode freezes the PC.
        prog[1] = 16'hF000;
        do_reset();
        run_prog(3, 0, 1, 1'b0, 1'b0);

        // Memory never responds: timeout after 15 WAIT cycles.
        do_reset();
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("to_req_seen", imem_req, 1);
        repeat (15) tick();
        chk("to_err_early", fetch_err, 0);
        chk("to_req_still", imem_req, 1);
        tick();
        chk("to_fetch_err", fetch_err, 1);
        chk("to_halted", halted, 1);
        chk("to_req_dropped", imem_req, 0);
        tick();
        chk("to_err_sticky", fetch_err, 1);

        // Reset mid-WAIT, with a late response arriving around reset.
        for (int i = 0; i < 16; i++) prog[i] = 16'h1234;
        do_reset();
        run_instr(4'd0, 0, 0, 1'b0, nxt, stop);
        tick();
        tick();
        chk("mw_in_wait", imem_req, 1);
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 16'hBEEF;
        tick();
        check_all_zero("mid_wait_reset");
        rst = 1'b1;
        tick();
        imem_valid = 1'b0;
        chk("late_instr", instr, 0);
        chk("late_instr_valid", instr_valid, 0);
        tick();
        chk("late_instr_wait", instr, 0);
        chk("late_valid_wait", instr_valid, 0);
        run_instr(4'd0, 1, 0, 1'b0, nxt, stop);
        chk("after_reset_pc", pc, 1);

        // Randomized programs, latencies, backpressure and zero flags.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) prog[i] = gen_word();
            do_reset();
            run_prog(25, 0, 0, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
